// File: rtl/aes_key_sched_iter.sv
// aes_key_sched_iter: iterative AES key expansion (128/192/256-bit keys).
// Computes one 32-bit schedule word per clock into a register file and
// exposes round keys through a combinational read port once complete.
// Optional feature macro: AES_KSCHED_ZEROIZE_EN adds a 'zeroize' input
// that wipes the stored schedule in one cycle.
module aes_key_sched_iter #(
  parameter int NK_MAX = 8,
  parameter int NR_MAX = NK_MAX + 6,
  parameter int NW     = 4 * (NR_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef AES_KSCHED_ZEROIZE_EN
  input  logic                  zeroize,
`endif
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [32*NK_MAX-1:0]  key,
  input  logic [1:0]            key_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            nr,
  input  logic [3:0]            rk_idx,
  output logic [127:0]          rk_data
);

  // Word index width: the largest schedule (60 words) fits in 6 bits.
  localparam int IW = 6;

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  // S-box computed algebraically: inverse as x^254, then the affine map.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int n = 0; n < 7; n++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  // Byte 0 lives in bits [7:0], so rotating byte 0 out to byte 3 is a right shift.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  state_t         state_q;
  logic [31:0]    w_q [NW];
  logic [3:0]     nk_q;
  logic [3:0]     nr_q;
  logic [3:0]     k_q;
  logic [IW-1:0]  i_q;
  logic [IW-1:0]  last_q;
  logic [7:0]     rcon_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;

  logic           zero_req;
  logic [3:0]     nk_d;
  logic [3:0]     nr_d;
  logic           load_ok;
  logic [IW-1:0]  idx_prev;
  logic [IW-1:0]  idx_old;
  logic [31:0]    prev_w;
  logic [31:0]    old_w;
  logic [31:0]    temp_d;
  logic [31:0]    word_d;
  logic           rd_en;

`ifdef AES_KSCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign key_ready = (state_q != S_EXPAND);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign nr        = nr_q;

  // Decode the requested key length and whether this instance can hold it.
  always_comb begin
    nk_d = 4'd0;
    case (key_len)
      2'd0:    nk_d = 4'd4;
      2'd1:    nk_d = 4'd6;
      2'd2:    nk_d = 4'd8;
      default: nk_d = 4'd0;
    endcase
    nr_d    = nk_d + 4'd6;
    load_ok = (key_len != 2'd3) && (nk_d <= 4'(NK_MAX));
  end

  // Next schedule word from w[i-1] and w[i-Nk]; k_q holds i mod Nk.
  always_comb begin
    idx_prev = i_q - IW'(1);
    idx_old  = i_q - IW'(nk_q);
    prev_w   = (idx_prev < IW'(NW)) ? w_q[idx_prev] : 32'h0;
    old_w    = (idx_old  < IW'(NW)) ? w_q[idx_old]  : 32'h0;
    if (k_q == 4'd0)
      temp_d = sub_word(rot_word(prev_w)) ^ {24'h0, rcon_q};
    else if (nk_q == 4'd8 && k_q == 4'd4)
      temp_d = sub_word(prev_w);
    else
      temp_d = prev_w;
    word_d = old_w ^ temp_d;
  end

  // Control FSM and schedule storage; zeroize outranks any load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      for (int j = 0; j < NW; j++) w_q[j] <= 32'h0;
      nk_q    <= 4'd0;
      nr_q    <= 4'd0;
      k_q     <= 4'd0;
      i_q     <= '0;
      last_q  <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (zero_req) begin
        for (int j = 0; j < NW; j++) w_q[j] <= 32'h0;
        nr_q    <= 4'd0;
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (key_valid) begin
              if (load_ok) begin
                for (int j = 0; j < NK_MAX; j++)
                  if (4'(j) < nk_d) w_q[j] <= key[32*j +: 32];
                nk_q    <= nk_d;
                nr_q    <= nr_d;
                last_q  <= {nr_d, 2'b11};
                i_q     <= IW'(nk_d);
                k_q     <= 4'd0;
                rcon_q  <= 8'h01;
                state_q <= S_EXPAND;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_EXPAND: begin
            w_q[i_q] <= word_d;
            if (k_q == 4'd0) rcon_q <= xtime(rcon_q);
            k_q <= (k_q == nk_q - 4'd1) ? 4'd0 : k_q + 4'd1;
            if (i_q == last_q) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              i_q <= i_q + IW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_en = (state_q == S_DONE) && (rk_idx <= nr_q);

  // Round-key read port: four word lanes of the selected round.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rk
    logic [IW-1:0] ridx;
    assign ridx = IW'({rk_idx, 2'b00}) + IW'(gi);
    assign rk_data[32*gi +: 32] = (rd_en && (ridx < IW'(NW))) ? w_q[ridx] : 32'h0;
  end

endmodule

// File: tb/tb_aes_key_sched_iter.sv
// Directed bench for aes_key_sched_iter using FIPS-197 appendix vectors.
module tb_aes_key_sched_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key;
  logic [1:0]   key_len;
  logic         busy;
  logic         done;
  logic         err;
  logic [3:0]   nr;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
`ifdef AES_KSCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  int errors = 0;
  int checks = 0;

  aes_key_sched_iter #(.NK_MAX(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_KSCHED_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .key_len   (key_len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .nr        (nr),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data)
  );

  always #5 clk = ~clk;

  // FIPS-197 byte strings (first byte leftmost).
  localparam logic [127:0] K128     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [191:0] K192     = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [255:0] K256     = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  // Reverse a right-aligned nb-byte string so its first byte lands in bits [7:0].
  function automatic logic [255:0] brev(input logic [255:0] s, input int nb);
    logic [255:0] r;
    r = '0;
    for (int j = 0; j < nb; j++) r[8*j +: 8] = s[8*(nb-1-j) +: 8];
    return r;
  endfunction

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [255:0] k, input logic [1:0] len);
    key       = k;
    key_len   = len;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  // Ticks from the accept edge until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int err_seen;
    rst_n     = 1'b1;
    key_valid = 1'b0;
    key       = '0;
    key_len   = 2'd0;
    rk_idx    = 4'd0;
`ifdef AES_KSCHED_ZEROIZE_EN
    zeroize   = 1'b0;
`endif
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk_eq("rst_key_ready", 128'(key_ready), 128'(1));
    chk_eq("rst_done",      128'(done),      128'(0));
    chk_eq("rst_busy",      128'(busy),      128'(0));
    chk_eq("rst_err",       128'(err),       128'(0));
    chk_eq("rst_nr",        128'(nr),        128'(0));
    chk_eq("rst_rk",        rk_data,         128'(0));
    rst_n = 1'b1;
    tick();

    // AES-128 from IDLE
    load(brev(256'(K128), 16), 2'd0);
    chk_eq("a128_busy",  128'(busy),      128'(1));
    chk_eq("a128_ready", 128'(key_ready), 128'(0));
    wait_done(n);
    chk_eq("a128_latency", 128'(n),  128'(40));
    chk_eq("a128_nr",      128'(nr), 128'(10));
    rk_idx = 4'd0;  #1;
    chk_eq("a128_rk0",  rk_data, 128'(brev(256'(K128), 16)));
    rk_idx = 4'd1;  #1;
    chk_eq("a128_rk1",  rk_data, 128'(brev(256'(RK128_1), 16)));
    rk_idx = 4'd10; #1;
    chk_eq("a128_rk10", rk_data, 128'(brev(256'(RK128_10), 16)));
    rk_idx = 4'd11; #1;
    chk_eq("a128_rk11", rk_data, 128'(0));

    // Illegal key length while DONE: one err pulse, schedule untouched
    rk_idx = 4'd10;
    load(256'hdeadbeef, 2'd3);
    chk_eq("ill_err",   128'(err),  128'(1));
    chk_eq("ill_done",  128'(done), 128'(1));
    chk_eq("ill_nr",    128'(nr),   128'(10));
    chk_eq("ill_rk10",  rk_data,    128'(brev(256'(RK128_10), 16)));
    tick();
    chk_eq("ill_err_gone", 128'(err), 128'(0));

    // AES-192 restart from DONE, key_valid held (with junk) during expansion
    load(brev(256'(K192), 24), 2'd1);
    chk_eq("a192_done_drop", 128'(done), 128'(0));
    key_valid = 1'b1;
    key       = '1;
    key_len   = 2'd3;
    err_seen  = 0;
    n = 0;
    while (!done && n < 200) begin
      if (n == 30) key_valid = 1'b0;
      tick();
      n++;
      if (err) err_seen++;
    end
    key_valid = 1'b0;
    chk_eq("a192_hold_no_err", 128'(err_seen), 128'(0));
    chk_eq("a192_latency", 128'(n),  128'(46));
    chk_eq("a192_nr",      128'(nr), 128'(12));
    rk_idx = 4'd12; #1;
    chk_eq("a192_rk12", rk_data, 128'(brev(256'(RK192_12), 16)));
    rk_idx = 4'd13; #1;
    chk_eq("a192_rk13", rk_data, 128'(0));

    // AES-256
    load(brev(K256, 32), 2'd2);
    wait_done(n);
    chk_eq("a256_latency", 128'(n),  128'(52));
    chk_eq("a256_nr",      128'(nr), 128'(14));
    rk_idx = 4'd14; #1;
    chk_eq("a256_rk14", rk_data, 128'(brev(256'(RK256_14), 16)));

    // Reset at EXPAND cycle 20, then reload AES-128
    rk_idx = 4'd0;
    load(brev(256'(K128), 16), 2'd0);
    for (int c = 0; c < 20; c++) tick();
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_ready", 128'(key_ready), 128'(1));
    chk_eq("mid_rst_done",  128'(done),      128'(0));
    chk_eq("mid_rst_busy",  128'(busy),      128'(0));
    chk_eq("mid_rst_err",   128'(err),       128'(0));
    chk_eq("mid_rst_nr",    128'(nr),        128'(0));
    chk_eq("mid_rst_rk",    rk_data,         128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    load(brev(256'(K128), 16), 2'd0);
    wait_done(n);
    chk_eq("reload_latency", 128'(n), 128'(40));
    rk_idx = 4'd10; #1;
    chk_eq("reload_rk10", rk_data, 128'(brev(256'(RK128_10), 16)));

`ifdef AES_KSCHED_ZEROIZE_EN
    // Zeroize in DONE with a simultaneous legal load: zeroize wins, no err
    rk_idx    = 4'd0;
    zeroize   = 1'b1;
    key_valid = 1'b1;
    key       = brev(K256, 32);
    key_len   = 2'd2;
    tick();
    zeroize   = 1'b0;
    key_valid = 1'b0;
    chk_eq("zero_done", 128'(done), 128'(0));
    chk_eq("zero_busy", 128'(busy), 128'(0));
    chk_eq("zero_err",  128'(err),  128'(0));
    chk_eq("zero_nr",   128'(nr),   128'(0));
    chk_eq("zero_rk",   rk_data,    128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_iter.md
AES_KEY_SCHED_ITER -- requirements
Module: aes_key_sched_iter

Interface
REQ-001 SHALL have parameter NK_MAX, default 8, meaning the largest key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 SHALL have derived parameter NR_MAX = NK_MAX+6 and word depth NW = 4*(NR_MAX+1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_valid, input, 1 bit: a key load is requested.
REQ-006 SHALL have port key_ready, output, 1 bit: a load is accepted when key_valid && key_ready.
REQ-007 SHALL have port key, input, 32*NK_MAX bits: key word i = key[32*i+:32], with key byte 0 at key[7:0].
REQ-008 SHALL have port key_len, input, 2 bits: 0 = AES-128 (Nk=4), 1 = AES-192 (Nk=6), 2 = AES-256 (Nk=8), 3 = illegal.
REQ-009 SHALL have port busy, output, 1 bit: expansion in progress.
REQ-010 SHALL have port done, output, 1 bit: the schedule is complete and readable; it stays high until the next accept or reset.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on a rejected load.
REQ-012 SHALL have port nr, output, 4 bits: round count Nr of the stored schedule.
REQ-013 SHALL have port rk_idx, input, 4 bits: round-key read index.
REQ-014 SHALL have port rk_data, output, 128 bits: {w[4i+3], w[4i+2], w[4i+1], w[4i]}, combinational read.

Function
REQ-015 SHALL implement states IDLE, EXPAND and DONE, with key_ready = (state != EXPAND).
REQ-016 SHALL, on accept with key_len <= 2 and Nk <= NK_MAX:
- write the Nk key words into w[0..Nk-1];
- set i = Nk, nr = Nk+6, Rcon = 8'h01;
- go to EXPAND.
REQ-017 SHALL, on accept with key_len = 3 or Nk > NK_MAX, pulse err for one cycle and leave state, storage, nr and done unchanged.
REQ-018 SHALL compute exactly one word per EXPAND cycle:
- w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {24'h0, Rcon} when i mod Nk == 0, and then Rcon <= xtime(Rcon);
- w[i] = w[i-Nk] ^ SubWord(w[i-1]) when Nk == 8 and i mod Nk == 4;
- w[i] = w[i-Nk] ^ w[i-1] otherwise.
REQ-019 SHALL use the shared SubWord/RotWord functions; no new S-box table.
REQ-020 SHALL track i mod Nk with a wrap counter (0..Nk-1), not a divider.
REQ-021 SHALL, after writing w[4*(Nr+1)-1], go to DONE on the same edge, so that done and !busy are visible the next cycle.
REQ-022 SHALL complete in the following cycles from the accept edge to done high: AES-128 40, AES-192 46, AES-256 52.
REQ-023 SHALL, in DONE, accept a new key (restart); done drops on the accept edge.
REQ-024 SHALL keep key_valid ignored during EXPAND, with no err pulse.
REQ-025 SHALL drive rk_data = 0 unless state == DONE and rk_idx <= nr.
REQ-026 SHALL keep rk_data stable in DONE regardless of key_valid while key_ready is low (it is not low in DONE; the accept edge ends DONE).

Reset
REQ-027 SHALL, on rst_n low, immediately force state = IDLE, all w = 0, nr = 0, Rcon = 8'h01, and done = busy = err = 0; key_ready = 1.
REQ-028 SHALL, on reset mid-EXPAND, abandon the partial schedule; the first accept after release starts from scratch.

Configuration
REQ-029 SHALL provide macro AES_KSCHED_ZEROIZE_EN, which when defined adds input port zeroize (1 bit).
REQ-030 SHALL, with AES_KSCHED_ZEROIZE_EN defined, on zeroize high in any state:
- clear all w and nr in one cycle;
- go to IDLE and drop done/busy;
- take priority over a simultaneous key accept, which is then not accepted and raises no err.
REQ-031 SHALL, without AES_KSCHED_ZEROIZE_EN, have no zeroize port; storage is cleared only by rst_n.

Verification
REQ-032 SHALL cover AES-128: FIPS-197 key 2b7e1516...09cf4f3c (byte-reversed onto key) -> done at +40 cycles; rk_idx=10 reads FIPS round 10 d014f9a8 c9ee2589 e13f0cc8 b6630ca6 (byte-reversed per word).
REQ-033 SHALL cover AES-192: key 8e73b0f7...522c6b7b -> done at +46, nr=12; rk_idx=12 reads e98ba06f 448c773c 8ecc7204 01002202; rk_idx=13 reads 0.
REQ-034 SHALL cover AES-256: key 603deb10...0914dff4 -> done at +52, nr=14; rk_idx=14 reads fe4890d1 e6188d0b 046df344 706c631e.
REQ-035 SHALL cover illegal and busy loads: key_len=3 in DONE -> err one pulse, stored schedule unchanged; key_valid held during EXPAND -> no accept, and latency unchanged.
REQ-036 SHALL cover reset and restart: rst_n low at EXPAND cycle 20 -> all outputs 0 and key_ready=1; then AES-128 reload -> correct round keys at +40; with AES_KSCHED_ZEROIZE_EN, zeroize in DONE -> rk_data=0 and done=0 next cycle.
